adc_sample_packer: RTL and testbench

ADC_SAMPLE_PACKER -- requirements
Module: adc_sample_packer

---
 rtl/adc_sample_packer_if.sv | 48 ++++
 rtl/adc_sample_packer.sv | 158 +++++++++++++++
 tb/tb_adc_sample_packer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/adc_sample_packer_if.sv
// Sample-packer bus bundle: capture input, FIFO read port, DMA handshake and overflow status.
// The slave modport is the packer side; the master modport is the host/converter side.
interface adc_sample_packer_if #(
   parameter int unsigned DEPTH_LOG2 = 4
);
   logic                  ENABLE;
   logic [15:0]           ADC_DATA;
   logic                  ADC_DATA_VALID;
   logic                  RD_EN;
   logic [31:0]           RD_DATA;
   logic [DEPTH_LOG2:0]   LEVEL;
   logic                  SDMA_REQ;
   logic                  SDMA_ACTIVE;
   logic                  SDMA_DONE;
   logic                  SDMA_IRQ;
   logic                  CLR_OVF;
   logic                  OVERFLOW;

   modport slave (
      input  ENABLE,
      input  ADC_DATA,
      input  ADC_DATA_VALID,
      input  RD_EN,
      output RD_DATA,
      output LEVEL,
      output SDMA_REQ,
      input  SDMA_ACTIVE,
      input  SDMA_DONE,
      output SDMA_IRQ,
      input  CLR_OVF,
      output OVERFLOW
   );

   modport master (
      output ENABLE,
      output ADC_DATA,
      output ADC_DATA_VALID,
      output RD_EN,
      input  RD_DATA,
      input  LEVEL,
      input  SDMA_REQ,
      output SDMA_ACTIVE,
      output SDMA_DONE,
      input  SDMA_IRQ,
      output CLR_OVF,
      input  OVERFLOW
   );
endinterface

// File: rtl/adc_sample_packer.sv
// ADC sample packer: forms 32-bit words from 16-bit samples into a FWFT FIFO with DMA burst FSM.
// Define ADC_PACKER_PACK2_EN to pack two samples per word; otherwise one zero-extended sample.
module adc_sample_packer #(
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter int unsigned THRESHOLD  = 8
) (
   input  logic                WB_CLK,
   input  logic                WB_RST,
   adc_sample_packer_if.slave  bus
);

   localparam int unsigned         Depth     = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FullLvl   = (DEPTH_LOG2 + 1)'(Depth);
   localparam logic [DEPTH_LOG2:0] ThreshLvl = (DEPTH_LOG2 + 1)'(THRESHOLD);
   localparam logic [DEPTH_LOG2:0] LvlOne    = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PtrOne  = DEPTH_LOG2'(1);

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StBusy,
      StIrq
   } dma_state_e;

   logic [31:0]           mem_q [Depth];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   level_q, level_d;
   logic                  overflow_q, overflow_d;
   dma_state_e            state_q, state_d;
   logic                  sdma_req_q, sdma_req_d;
   logic                  sdma_irq_q, sdma_irq_d;

   logic                  accept;
   logic                  wr_req;
   logic [31:0]           wr_word;
   logic                  full;
   logic                  empty;
   logic                  do_push;
   logic                  do_pop;

   assign accept = bus.ENABLE & bus.ADC_DATA_VALID;

`ifdef ADC_PACKER_PACK2_EN
   logic        pending_q, pending_d;
   logic [15:0] half_q, half_d;

   always_comb begin
      pending_d = pending_q;
      half_d    = half_q;
      wr_req    = 1'b0;
      wr_word   = {bus.ADC_DATA, half_q};
      if (!bus.ENABLE) begin
         pending_d = 1'b0;
      end else if (bus.ADC_DATA_VALID) begin
         if (pending_q) begin
            wr_req    = 1'b1;
            pending_d = 1'b0;
         end else begin
            half_d    = bus.ADC_DATA;
            pending_d = 1'b1;
         end
      end
   end

   always_ff @(posedge WB_CLK or posedge WB_RST) begin
      if (WB_RST) begin
         pending_q <= 1'b0;
         half_q    <= 16'h0000;
      end else begin
         pending_q <= pending_d;
         half_q    <= half_d;
      end
   end
`else
   always_comb begin
      wr_req  = accept;
      wr_word = {16'h0000, bus.ADC_DATA};
   end
`endif

   // A pop on a full FIFO frees the slot the coincident write lands in.
   always_comb begin
      full       = (level_q == FullLvl);
      empty      = (level_q == '0);
      do_pop     = bus.RD_EN & ~empty;
      do_push    = wr_req & (~full | do_pop);
      wr_ptr_d   = do_push ? wr_ptr_q + PtrOne : wr_ptr_q;
      rd_ptr_d   = do_pop ? rd_ptr_q + PtrOne : rd_ptr_q;
      level_d    = level_q;
      if (do_push && !do_pop) begin
         level_d = level_q + LvlOne;
      end else if (do_pop && !do_push) begin
         level_d = level_q - LvlOne;
      end
      overflow_d = overflow_q;
      if (wr_req && full && !do_pop) begin
         overflow_d = 1'b1;
      end else if (bus.CLR_OVF) begin
         overflow_d = 1'b0;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge WB_CLK) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wr_word;
      end
   end

   always_ff @(posedge WB_CLK or posedge WB_RST) begin
      if (WB_RST) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (level_q >= ThreshLvl) state_d = StReq;
         StReq:   if (bus.SDMA_ACTIVE) state_d = StBusy;
         StBusy:  if (bus.SDMA_DONE) state_d = StIrq;
         StIrq:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
      sdma_req_d = (state_d == StReq);
      sdma_irq_d = (state_d == StIrq);
   end

   always_ff @(posedge WB_CLK or posedge WB_RST) begin
      if (WB_RST) begin
         state_q    <= StIdle;
         sdma_req_q <= 1'b0;
         sdma_irq_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sdma_req_q <= sdma_req_d;
         sdma_irq_q <= sdma_irq_d;
      end
   end

   always_comb begin
      bus.RD_DATA  = mem_q[rd_ptr_q];
      bus.LEVEL    = level_q;
      bus.SDMA_REQ = sdma_req_q;
      bus.SDMA_IRQ = sdma_irq_q;
      bus.OVERFLOW = overflow_q;
   end

endmodule

// File: tb/tb_adc_sample_packer.sv
// Directed bench for adc_sample_packer; covers the packed format when ADC_PACKER_PACK2_EN is defined.
module tb_adc_sample_packer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   adc_sample_packer_if #(.DEPTH_LOG2(4)) bus ();

   adc_sample_packer #(
      .DEPTH_LOG2(4),
      .THRESHOLD (8)
   ) dut (
      .WB_CLK(clk),
      .WB_RST(rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_sample(input logic [15:0] d);
      bus.ADC_DATA       = d;
      bus.ADC_DATA_VALID = 1'b1;
      tick();
      bus.ADC_DATA_VALID = 1'b0;
   endtask

   task automatic pop();
      bus.RD_EN = 1'b1;
      tick();
      bus.RD_EN = 1'b0;
   endtask

   task automatic pulse_active();
      bus.SDMA_ACTIVE = 1'b1;
      tick();
      bus.SDMA_ACTIVE = 1'b0;
   endtask

   task automatic pulse_done();
      bus.SDMA_DONE = 1'b1;
      tick();
      bus.SDMA_DONE = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.ENABLE         = 1'b0;
      bus.ADC_DATA       = 16'h0000;
      bus.ADC_DATA_VALID = 1'b0;
      bus.RD_EN          = 1'b0;
      bus.SDMA_ACTIVE    = 1'b0;
      bus.SDMA_DONE      = 1'b0;
      bus.CLR_OVF        = 1'b0;
      #2;
      check_eq("rst_level", 32'(bus.LEVEL), 32'd0);
      check_eq("rst_req", 32'(bus.SDMA_REQ), 32'd0);
      check_eq("rst_irq", 32'(bus.SDMA_IRQ), 32'd0);
      check_eq("rst_ovf", 32'(bus.OVERFLOW), 32'd0);
      repeat (2) tick();
      rst = 1'b0;
      bus.ENABLE = 1'b1;

`ifdef ADC_PACKER_PACK2_EN
      push_sample(16'hAAAA);
      check_eq("pk_half_level", 32'(bus.LEVEL), 32'd0);
      push_sample(16'h5555);
      check_eq("pk_word_level", 32'(bus.LEVEL), 32'd1);
      check_eq("pk_word_data", bus.RD_DATA, 32'h5555AAAA);
      push_sample(16'h1234);
      bus.ENABLE = 1'b0;
      tick();
      check_eq("pk_drop_level", 32'(bus.LEVEL), 32'd1);
      bus.ENABLE = 1'b1;
      push_sample(16'h1111);
      push_sample(16'h2222);
      check_eq("pk_realign_level", 32'(bus.LEVEL), 32'd2);
      pop();
      check_eq("pk_realign_data", bus.RD_DATA, 32'h22221111);
      pop();
      check_eq("pk_drain_level", 32'(bus.LEVEL), 32'd0);
`else
      // Disabled capture and empty pops change nothing.
      bus.ENABLE = 1'b0;
      push_sample(16'h00FF);
      check_eq("dis_level", 32'(bus.LEVEL), 32'd0);
      bus.ENABLE = 1'b1;
      pop();
      check_eq("empty_pop_level", 32'(bus.LEVEL), 32'd0);

      for (int i = 1; i <= 8; i++) push_sample(16'(i));
      check_eq("fill8_level", 32'(bus.LEVEL), 32'd8);
      check_eq("fill8_req_early", 32'(bus.SDMA_REQ), 32'd0);
      tick();
      check_eq("fill8_req", 32'(bus.SDMA_REQ), 32'd1);
      pulse_done();
      check_eq("done_in_req_req", 32'(bus.SDMA_REQ), 32'd1);
      check_eq("done_in_req_irq", 32'(bus.SDMA_IRQ), 32'd0);
      for (int i = 1; i <= 8; i++) begin
         check_eq("fill8_data", bus.RD_DATA, 32'(i));
         pop();
      end
      check_eq("fill8_drain", 32'(bus.LEVEL), 32'd0);
      pulse_active();
      check_eq("busy_req", 32'(bus.SDMA_REQ), 32'd0);
      pulse_done();
      check_eq("irq_pulse", 32'(bus.SDMA_IRQ), 32'd1);
      tick();
      check_eq("irq_end", 32'(bus.SDMA_IRQ), 32'd0);
      tick();
      check_eq("idle_req", 32'(bus.SDMA_REQ), 32'd0);

      for (int i = 0; i < 16; i++) push_sample(16'h0100 + 16'(i));
      check_eq("full_level", 32'(bus.LEVEL), 32'd16);
      check_eq("full_ovf", 32'(bus.OVERFLOW), 32'd0);
      push_sample(16'h0110);
      check_eq("ovf_level", 32'(bus.LEVEL), 32'd16);
      check_eq("ovf_set", 32'(bus.OVERFLOW), 32'd1);
      check_eq("ovf_head", bus.RD_DATA, 32'h0000_0100);
      bus.CLR_OVF = 1'b1;
      tick();
      bus.CLR_OVF = 1'b0;
      check_eq("ovf_clr", 32'(bus.OVERFLOW), 32'd0);
      bus.CLR_OVF = 1'b1;
      push_sample(16'h0111);
      bus.CLR_OVF = 1'b0;
      check_eq("ovf_set_wins", 32'(bus.OVERFLOW), 32'd1);
      bus.CLR_OVF = 1'b1;
      tick();
      bus.CLR_OVF = 1'b0;
      check_eq("ovf_clr2", 32'(bus.OVERFLOW), 32'd0);
      bus.RD_EN = 1'b1;
      push_sample(16'h0200);
      bus.RD_EN = 1'b0;
      check_eq("full_rw_level", 32'(bus.LEVEL), 32'd16);
      check_eq("full_rw_ovf", 32'(bus.OVERFLOW), 32'd0);
      for (int i = 1; i < 16; i++) begin
         check_eq("full_drain_data", bus.RD_DATA, 32'h0000_0100 + 32'(i));
         pop();
      end
      check_eq("full_drain_last", bus.RD_DATA, 32'h0000_0200);
      pop();
      check_eq("full_drain_level", 32'(bus.LEVEL), 32'd0);

      // FSM reached REQ during the fill; move to BUSY then reset with data queued.
      pulse_active();
      check_eq("busy2_req", 32'(bus.SDMA_REQ), 32'd0);
      for (int i = 0; i < 5; i++) push_sample(16'h0300 + 16'(i));
      check_eq("busy2_level", 32'(bus.LEVEL), 32'd5);
      rst = 1'b1;
      #2;
      check_eq("arst_level", 32'(bus.LEVEL), 32'd0);
      check_eq("arst_req", 32'(bus.SDMA_REQ), 32'd0);
      check_eq("arst_irq", 32'(bus.SDMA_IRQ), 32'd0);
      check_eq("arst_ovf", 32'(bus.OVERFLOW), 32'd0);
      tick();
      rst = 1'b0;
      pulse_active();
      pulse_done();
      check_eq("post_rst_irq", 32'(bus.SDMA_IRQ), 32'd0);
      tick();
      check_eq("post_rst_irq2", 32'(bus.SDMA_IRQ), 32'd0);
      check_eq("post_rst_req", 32'(bus.SDMA_REQ), 32'd0);

      for (int i = 0; i < 48; i++) begin
         push_sample(16'h4000 + 16'(i));
         check_eq("wrap_level1", 32'(bus.LEVEL), 32'd1);
         check_eq("wrap_data", bus.RD_DATA, 32'h0000_4000 + 32'(i));
         pop();
         check_eq("wrap_level0", 32'(bus.LEVEL), 32'd0);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
